// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcode constants, FSM state
// encoding and the instruction byte field helpers.
package instr_sequencer_pkg;

  localparam logic [1:0] OP_LDI = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IMM  = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } seq_state_t;

  function automatic logic [1:0] ir_opcode(input logic [7:0] ir);
    return ir[7:6];
  endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Multi-cycle control unit feeding a 4x8 register file: accepts instruction
// bytes over valid/ready, decodes them, and retires each one with a single write.
module instr_sequencer
  import instr_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [7:0] instr_byte,
  output logic       instr_ready,
  output logic [1:0] aReg_select,
  output logic [1:0] bReg_select,
  output logic [1:0] dest_select,
  output logic       load_enable,
  output logic [1:0] alu_op,
  output logic       wb_sel,
  output logic [7:0] imm_data,
  output logic       busy,
  output logic [7:0] instr_count,
  output logic [1:0] dbg_state
);

  // Handshake: a byte moves on a rising edge where instr_valid and
  // instr_ready are both high; instr_ready is high only in IDLE and IMM.
  seq_state_t r_state;
  logic [7:0] r_ir;
  logic [7:0] r_imm;
  logic [7:0] r_count;
  logic       r_load;
  logic       r_wb_sel;
  logic       w_xfer;

  assign instr_ready = (r_state == ST_IDLE) || (r_state == ST_IMM);
  assign busy        = (r_state != ST_IDLE);
  assign w_xfer      = instr_valid && instr_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_ir     <= 8'h00;
      r_imm    <= 8'h00;
      r_count  <= 8'h00;
      r_load   <= 1'b0;
      r_wb_sel <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_load <= 1'b0;
          if (w_xfer) begin
            r_ir     <= instr_byte;
            // wb_sel is registered so it reads 0 out of reset even though IR=0 decodes as LDI
            r_wb_sel <= (ir_opcode(instr_byte) == OP_LDI);
            r_state  <= (ir_opcode(instr_byte) == OP_LDI) ? ST_IMM : ST_EXEC;
          end
        end
        ST_IMM: begin
          if (w_xfer) begin
            r_imm   <= instr_byte;
            r_load  <= 1'b1;
            r_state <= ST_WB;
          end
        end
        ST_EXEC: begin
          r_load  <= 1'b1;
          r_state <= ST_WB;
        end
        ST_WB: begin
          r_load  <= 1'b0;
          r_count <= r_count + 8'd1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_load  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign aReg_select = r_ir[3:2];
  assign bReg_select = r_ir[1:0];
  assign dest_select = r_ir[5:4];
  assign alu_op      = ir_opcode(r_ir);
  assign wb_sel      = r_wb_sel;
  assign imm_data    = r_imm;
  assign load_enable = r_load;
  assign instr_count = r_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: steps through LDI, ALU, back-to-back,
// stalled-immediate, reset-in-WB and counter-wrap scenarios.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  logic       clk;
  logic       reset;
  logic       instr_valid;
  logic [7:0] instr_byte;
  logic       instr_ready;
  logic [1:0] aReg_select;
  logic [1:0] bReg_select;
  logic [1:0] dest_select;
  logic       load_enable;
  logic [1:0] alu_op;
  logic       wb_sel;
  logic [7:0] imm_data;
  logic       busy;
  logic [7:0] instr_count;
  logic [1:0] dbg_state;

  int total = 0;
  int bad   = 0;
  int pulses;

  instr_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_byte  (instr_byte),
    .instr_ready (instr_ready),
    .aReg_select (aReg_select),
    .bReg_select (bReg_select),
    .dest_select (dest_select),
    .load_enable (load_enable),
    .alu_op      (alu_op),
    .wb_sel      (wb_sel),
    .imm_data    (imm_data),
    .busy        (busy),
    .instr_count (instr_count),
    .dbg_state   (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle 1ns past it for driving and sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b0;
    instr_valid = 1'b0;
    instr_byte  = 8'h00;
    repeat (2) step();

    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_load", load_enable, 0);
    chk("rst_sel", {aReg_select, bReg_select, dest_select, alu_op}, 0);
    chk("rst_wb_sel", wb_sel, 0);
    chk("rst_imm", imm_data, 8'h00);
    chk("rst_count", instr_count, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    reset = 1'b1;
    step();

    // LDI r1, 0xA5
    instr_valid = 1'b1; instr_byte = 8'h10;
    step();
    chk("ldi_imm_state", dbg_state, ST_IMM);
    chk("ldi_imm_ready", instr_ready, 1);
    chk("ldi_imm_load", load_enable, 0);
    instr_byte = 8'hA5;
    step();
    chk("ldi_wb_load", load_enable, 1);
    chk("ldi_wb_dest", dest_select, 2'b01);
    chk("ldi_wb_sel", wb_sel, 1);
    chk("ldi_wb_imm", imm_data, 8'hA5);
    chk("ldi_wb_ready", instr_ready, 0);
    instr_valid = 1'b0;
    step();
    chk("ldi_done_load", load_enable, 0);
    chk("ldi_done_count", instr_count, 1);
    chk("ldi_done_busy", busy, 0);

    // ADD r0 <- r3 + r2
    instr_valid = 1'b1; instr_byte = 8'h4E;
    step();
    instr_valid = 1'b0;
    chk("add_exec_state", dbg_state, ST_EXEC);
    chk("add_a", aReg_select, 2'b11);
    chk("add_b", bReg_select, 2'b10);
    chk("add_op", alu_op, 2'b01);
    chk("add_dest", dest_select, 2'b00);
    chk("add_wb_sel", wb_sel, 0);
    chk("add_exec_load", load_enable, 0);
    chk("add_exec_ready", instr_ready, 0);
    step();
    chk("add_wb_load", load_enable, 1);
    step();
    chk("add_done_load", load_enable, 0);
    chk("add_done_count", instr_count, 2);

    // Back-to-back with instr_valid held high: 0x4E, 0x9B, 0xE4
    pulses = 0;
    instr_valid = 1'b1; instr_byte = 8'h4E;
    step();
    chk("b2b0_op", {alu_op, dest_select, aReg_select, bReg_select}, 8'h4E);
    chk("b2b0_ready", instr_ready, 0);
    pulses += int'(load_enable);
    instr_byte = 8'h9B;
    step();
    chk("b2b0_wb_ready", instr_ready, 0);
    pulses += int'(load_enable);
    step();
    chk("b2b1_idle_ready", instr_ready, 1);
    pulses += int'(load_enable);
    step();
    chk("b2b1_op", {alu_op, dest_select, aReg_select, bReg_select}, 8'h9B);
    pulses += int'(load_enable);
    instr_byte = 8'hE4;
    step(); pulses += int'(load_enable);
    step(); pulses += int'(load_enable);
    step();
    chk("b2b2_op", {alu_op, dest_select, aReg_select, bReg_select}, 8'hE4);
    chk("b2b2_state", dbg_state, ST_EXEC);
    pulses += int'(load_enable);
    instr_byte = 8'h00;
    step(); pulses += int'(load_enable);
    instr_valid = 1'b0;
    step(); pulses += int'(load_enable);
    chk("b2b_pulses", pulses, 3);
    chk("b2b_count", instr_count, 5);
    chk("b2b_idle", dbg_state, ST_IDLE);

    // Stalled immediate: LDI r3, gap of 5 cycles, then 0x7F
    instr_valid = 1'b1; instr_byte = 8'h30;
    step();
    instr_valid = 1'b0; instr_byte = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_state", dbg_state, ST_IMM);
      chk("stall_busy", busy, 1);
      chk("stall_load", load_enable, 0);
    end
    instr_valid = 1'b1; instr_byte = 8'h7F;
    step();
    instr_valid = 1'b0;
    chk("stall_wb_load", load_enable, 1);
    chk("stall_wb_dest", dest_select, 2'b11);
    chk("stall_wb_imm", imm_data, 8'h7F);
    chk("stall_wb_sel", wb_sel, 1);
    step();
    chk("stall_count", instr_count, 6);

    // Reset asserted in the middle of an ADD's WB cycle
    instr_valid = 1'b1; instr_byte = 8'h4E;
    step();
    step();
    chk("rwb_load_before", load_enable, 1);
    #2 reset = 1'b0;
    #1;
    chk("rwb_load", load_enable, 0);
    chk("rwb_state", dbg_state, ST_IDLE);
    chk("rwb_count", instr_count, 0);
    chk("rwb_ir", {alu_op, dest_select, aReg_select, bReg_select}, 8'h00);
    chk("rwb_imm", imm_data, 8'h00);
    step();
    chk("rwb_hold_state", dbg_state, ST_IDLE);
    chk("rwb_hold_ir", {alu_op, dest_select, aReg_select, bReg_select}, 8'h00);
    chk("rwb_hold_count", instr_count, 0);
    instr_valid = 1'b0;
    reset = 1'b1;
    step();

    // Counter wrap: 256 ADDs back to back
    pulses = 0;
    instr_valid = 1'b1; instr_byte = 8'h5B;
    for (int i = 0; i < 256; i++) begin
      step(); pulses += int'(load_enable);
      step(); pulses += int'(load_enable);
      if (i == 255) instr_valid = 1'b0;
      step(); pulses += int'(load_enable);
      if (i == 254) chk("wrap_255", instr_count, 255);
    end
    chk("wrap_pulses", pulses, 256);
    chk("wrap_zero", instr_count, 0);
    chk("wrap_idle", dbg_state, ST_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
